// File: rtl/data_mem_responder.sv
// data_mem_responder: serves 32-bit CPU data requests on a 64-bit pmem port (optional line buffer: DATA_MEM_RESPONDER_LINE_BUF_EN)
module data_mem_responder #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_mbe,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [63:0] pmem_wdata,
    input  logic [63:0] pmem_rdata,
    input  logic        pmem_resp
);
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, RESP} state_t;
    state_t      r_state, w_next;
    logic [28:0] r_tag;
    logic        r_sel;
    logic [31:0] r_wdata;
    logic [3:0]  r_mbe;
    logic [63:0] r_line;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_cnt;
    logic        w_hit;
    logic        w_timeout;
    function automatic logic [63:0] merge(input logic [63:0] line, input logic [31:0] d,
                                          input logic [3:0] be, input logic sel);
        merge = line;
        for (int i = 0; i < 4; i++)
            if (be[i]) merge[(sel ? 32 : 0) + i * 8 +: 8] = d[i * 8 +: 8];
    endfunction
`ifdef DATA_MEM_RESPONDER_LINE_BUF_EN
    logic        r_buf_v;
    logic [28:0] r_buf_tag;
    logic [63:0] r_buf_data;
    assign w_hit = r_buf_v && (r_buf_tag == mem_address[31:3]);
`else
    assign w_hit = 1'b0;
`endif
    assign pmem_read    = (r_state == RD) || (r_state == RMW_RD);
    assign pmem_write   = r_state == RMW_WR;
    assign pmem_address = {r_tag, 3'b000};
    assign pmem_wdata   = r_line;
    assign mem_resp     = r_state == RESP;
    assign mem_err      = mem_resp && r_err;
    assign mem_rdata    = r_rdata;
    assign w_timeout    = (TIMEOUT != 0) && (pmem_read || pmem_write) && !pmem_resp
                          && (r_cnt == TIMEOUT - 1);
    // next-state selection; a write outranks a simultaneous read
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = mem_write ? (mem_mbe == 4'd0 ? RESP : (w_hit ? RMW_WR : RMW_RD))
                            : mem_read ? (w_hit ? RESP : RD) : IDLE;
            RD:      w_next = (pmem_resp || w_timeout) ? RESP : RD;
            RMW_RD:  w_next = pmem_resp ? RMW_WR : (w_timeout ? RESP : RMW_RD);
            RMW_WR:  w_next = (pmem_resp || w_timeout) ? RESP : RMW_WR;
            default: w_next = IDLE;
        endcase
    end
    // state, request latch, line/merge datapath, timeout counter and line buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tag      <= '0;
            r_sel      <= 1'b0;
            r_wdata    <= '0;
            r_mbe      <= '0;
            r_line     <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
`ifdef DATA_MEM_RESPONDER_LINE_BUF_EN
            r_buf_v    <= 1'b0;
            r_buf_tag  <= '0;
            r_buf_data <= '0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                    if (mem_read || mem_write) begin
                        r_tag   <= mem_address[31:3];
                        r_sel   <= mem_address[2];
                        r_wdata <= mem_wdata;
                        r_mbe   <= mem_mbe;
                        r_rdata <= '0;
                    end
`ifdef DATA_MEM_RESPONDER_LINE_BUF_EN
                    if (mem_write && mem_mbe != 4'd0 && w_hit)
                        r_line <= merge(r_buf_data, mem_wdata, mem_mbe, mem_address[2]);
                    if (!mem_write && mem_read && w_hit)
                        r_rdata <= mem_address[2] ? r_buf_data[63:32] : r_buf_data[31:0];
`endif
                end
                RD: begin
                    if (pmem_resp) begin
                        r_rdata <= r_sel ? pmem_rdata[63:32] : pmem_rdata[31:0];
`ifdef DATA_MEM_RESPONDER_LINE_BUF_EN
                        r_buf_v    <= 1'b1;
                        r_buf_tag  <= r_tag;
                        r_buf_data <= pmem_rdata;
`endif
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
`ifdef DATA_MEM_RESPONDER_LINE_BUF_EN
                        r_buf_v <= 1'b0;
`endif
                    end else r_cnt <= r_cnt + 32'd1;
                end
                RMW_RD: begin
                    if (pmem_resp) begin
                        r_line <= merge(pmem_rdata, r_wdata, r_mbe, r_sel);
                        r_cnt  <= '0;
`ifdef DATA_MEM_RESPONDER_LINE_BUF_EN
                        r_buf_v    <= 1'b1;
                        r_buf_tag  <= r_tag;
                        r_buf_data <= pmem_rdata;
`endif
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
`ifdef DATA_MEM_RESPONDER_LINE_BUF_EN
                        r_buf_v <= 1'b0;
`endif
                    end else r_cnt <= r_cnt + 32'd1;
                end
                RMW_WR: begin
                    if (pmem_resp) begin
`ifdef DATA_MEM_RESPONDER_LINE_BUF_EN
                        r_buf_v    <= 1'b1;
                        r_buf_tag  <= r_tag;
                        r_buf_data <= r_line;
`endif
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
`ifdef DATA_MEM_RESPONDER_LINE_BUF_EN
                        r_buf_v <= 1'b0;
`endif
                    end else r_cnt <= r_cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
